// File: rtl/sample_buffer_ctrl.sv
// sample_buffer_ctrl
//   Circular-buffer controller that runs a simple dual-port sample RAM
//   (one write port, one read port, registered read data) as a FIFO between
//   the SAR ADC sample stream and the host readout logic.
//
// Parameters
//   ADDR_WIDTH  RAM address width, depth = 2**ADDR_WIDTH words
//   DATA_WIDTH  sample word width
//   THRESH      fill level at or above which irq_level asserts (1..depth)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   capture_en          gates the ADC stream; gated samples are not drops
//   s_valid, s_data     ADC sample strobe and data (no back-pressure)
//   rd_req              host read request, one word per cycle max
//   rd_valid, rd_data   read response, one cycle after an accepted request
//   flush               synchronous clear of pointers, level and flags
//   clr_ovf             clears overflow and drop_cnt
//   level, empty, full  fill count and its end-point flags
//   overflow, drop_cnt  sticky drop flag and saturating drop counter
//   irq_level           registered level >= THRESH indication
//   ram_we, ram_waddr, ram_din   RAM write port (combinational)
//   ram_re, ram_raddr            RAM read port (combinational)
//   ram_dout                     RAM read data, one cycle after ram_re
module sample_buffer_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int THRESH     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture_en,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  flush,
    input  logic                  clr_ovf,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic [15:0]           drop_cnt,
    output logic                  irq_level,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [ADDR_WIDTH:0]   THRESH_L = (ADDR_WIDTH+1)'(THRESH);
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   level_nxt;
    logic                  rd_pend;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  drop;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Level never exceeds depth, so its MSB alone marks a full buffer.
    assign empty = (level == '0);
    assign full  = level[ADDR_WIDTH];

    // Acceptance uses pre-edge full/empty, so a same-cycle read of a full
    // buffer does not make room for the write and a same-cycle write into an
    // empty buffer does not feed the read. The RAM therefore never sees a
    // read and a write to the same address in one cycle. Strobes are held
    // low while rst is asserted.
    assign wr_acc = ~rst & capture_en & s_valid & ~full & ~flush;
    assign drop   = ~rst & capture_en & s_valid &  full & ~flush;
    assign rd_acc = ~rst & rd_req & ~empty & ~flush;

    assign ram_we    = wr_acc;
    assign ram_waddr = wptr;
    assign ram_din   = s_data;
    assign ram_re    = rd_acc;
    assign ram_raddr = rptr;

    assign rd_valid  = rd_pend;
    assign rd_data   = ram_dout;

    always_comb begin
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + LVL_ONE;
            2'b01:   level_nxt = level - LVL_ONE;
            default: level_nxt = level;
        endcase
    end

    // State update; rd_pend tracks the RAM's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            rd_pend   <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            irq_level <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            rd_pend   <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            irq_level <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + PTR_ONE;
            if (rd_acc) rptr <= rptr + PTR_ONE;
            level     <= level_nxt;
            rd_pend   <= rd_acc;
            irq_level <= (level_nxt >= THRESH_L);
            // A drop in the same cycle as clr_ovf wins and restarts the count.
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= clr_ovf ? 16'd1 : sat_inc16(drop_cnt);
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sample_buffer_ctrl.sv
module tb_sample_buffer_ctrl;

    localparam int AW = 3;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          capture_en, s_valid, rd_req, flush, clr_ovf;
    logic [DW-1:0] s_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW:0]   level;
    logic          empty, full, overflow, irq_level;
    logic [15:0]   drop_cnt;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic          ram_we, ram_re;
    logic [DW-1:0] ram_din, ram_dout;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Sample RAM beside the controller: registered read data.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_raddr];
    end

    sample_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .THRESH(6)) dut (
        .clk(clk), .rst(rst), .capture_en(capture_en), .s_valid(s_valid),
        .s_data(s_data), .rd_req(rd_req), .rd_valid(rd_valid),
        .rd_data(rd_data), .flush(flush), .clr_ovf(clr_ovf), .level(level),
        .empty(empty), .full(full), .overflow(overflow), .drop_cnt(drop_cnt),
        .irq_level(irq_level), .ram_waddr(ram_waddr), .ram_we(ram_we),
        .ram_din(ram_din), .ram_raddr(ram_raddr), .ram_re(ram_re),
        .ram_dout(ram_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; inputs change and checks happen 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; capture_en = 1'b1; s_valid = 1'b1; rd_req = 1'b1;
        flush = 1'b0; clr_ovf = 1'b0; s_data = 32'h5A;
        #2;
        // Reset state, strobes suppressed even with requests present
        check("rst_we", ram_we, 0);
        check("rst_re", ram_re, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_irq", irq_level, 0);
        s_valid = 1'b0; rd_req = 1'b0;
        tick();
        rst = 1'b0;

        // Basic FIFO
        s_valid = 1'b1; s_data = 32'h11;
        #1 check("bf_we", ram_we, 1);
        check("bf_waddr", ram_waddr, 0);
        tick(); s_data = 32'h22;
        tick(); s_data = 32'h33;
        tick(); s_valid = 1'b0;
        check("bf_level3", level, 3);
        rd_req = 1'b1;
        #1 check("bf_re", ram_re, 1);
        check("bf_raddr", ram_raddr, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bf_rd_valid", rd_valid, 1);
            check("bf_rd_data", rd_data, 32'h11 * (i + 1));
            check("bf_level", level, 2 - i);
        end
        rd_req = 1'b0;
        check("bf_empty", empty, 1);
        tick();
        check("bf_no_valid", rd_valid, 0);

        // Full and drop: samples 0..9, last two dropped
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = i;
            tick();
            if (i == 6) check("fd_not_full7", full, 0);
            if (i == 7) check("fd_full8", full, 1);
        end
        check("fd_level", level, 8);
        check("fd_overflow", overflow, 1);
        check("fd_drop_cnt", drop_cnt, 2);
        check("fd_irq", irq_level, 1);
        // Drop coincident with clr_ovf: drop wins, count restarts at 1
        s_data = 32'hDD; clr_ovf = 1'b1;
        tick();
        check("fd_clr_drop_ovf", overflow, 1);
        check("fd_clr_drop_cnt", drop_cnt, 1);
        s_valid = 1'b0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("fd_clr_ovf", overflow, 0);
        check("fd_clr_cnt", drop_cnt, 0);
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("fd_rd_valid", rd_valid, 1);
            check("fd_rd_data", rd_data, i);
        end
        rd_req = 1'b0;
        check("fd_empty", empty, 1);

        // Wrap-around: prefill 4, then 20 cycles of write+read
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = i;
            tick();
        end
        check("wr_level4", level, 4);
        rd_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = i + 4;
            tick();
            check("wr_rd_data", rd_data, i);
            check("wr_rd_valid", rd_valid, 1);
            check("wr_level", level, 4);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr_drain", rd_data, 20 + i);
        end
        rd_req = 1'b0;
        check("wr_empty", empty, 1);

        // Boundary refusals
        rd_req = 1'b1;
        #1 check("br_empty_re", ram_re, 0);
        tick();
        check("br_empty_valid", rd_valid, 0);
        s_valid = 1'b1; s_data = 32'hA0;
        #1 check("br_simul_we", ram_we, 1);
        check("br_simul_re", ram_re, 0);
        tick();
        rd_req = 1'b0;
        check("br_simul_level", level, 1);
        check("br_simul_valid", rd_valid, 0);
        for (int i = 1; i < 8; i++) begin
            s_data = 32'hA0 + i;
            tick();
        end
        check("br_full", full, 1);
        s_data = 32'hEE; rd_req = 1'b1;
        #1 check("br_full_we", ram_we, 0);
        check("br_full_re", ram_re, 1);
        tick();
        s_valid = 1'b0;
        check("br_full_level", level, 7);
        check("br_full_drop", drop_cnt, 1);
        check("br_full_ovf", overflow, 1);
        check("br_full_data", rd_data, 32'hA0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("br_drain", rd_data, 32'hA0 + i);
        end
        rd_req = 1'b0;
        check("br_empty", empty, 1);

        // Threshold: 5 -> 6 -> 5
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 32'hC0 + i;
            tick();
        end
        check("th_level5", level, 5);
        check("th_irq5", irq_level, 0);
        s_data = 32'hC5;
        tick();
        s_valid = 1'b0;
        check("th_level6", level, 6);
        check("th_irq6", irq_level, 1);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("th_level_back5", level, 5);
        check("th_irq_back", irq_level, 0);

        // Flush with level=5, overflow still set from the full-buffer drop
        check("fl_pre_ovf", overflow, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_level", level, 0);
        check("fl_empty", empty, 1);
        check("fl_ovf", overflow, 0);
        check("fl_drop", drop_cnt, 0);
        check("fl_irq", irq_level, 0);
        s_valid = 1'b1; s_data = 32'hF0;
        #1 check("fl_waddr", ram_waddr, 0);
        check("fl_we", ram_we, 1);
        tick();
        s_valid = 1'b0;

        // Asynchronous reset in the middle of an accepted read
        rd_req = 1'b1;
        #1 check("rs_raddr", ram_raddr, 0);
        check("rs_re", ram_re, 1);
        #1 rst = 1'b1;
        #1 check("rs_re_off", ram_re, 0);
        check("rs_level", level, 0);
        check("rs_empty", empty, 1);
        tick();
        check("rs_no_valid", rd_valid, 0);
        check("rs_ovf", overflow, 0);
        rd_req = 1'b0;
        rst = 1'b0;
        tick();
        check("rs_still_no_valid", rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sample_buffer_ctrl.md
# sample_buffer_ctrl

Circular-buffer controller that sequences the simple dual-port sample RAM (one write port, one read port, registered read data) as a FIFO between the SAR ADC sample stream and the host readout logic. It generates all RAM port signals and tracks read/write pointers, fill level, overflow and dropped-sample count. It also raises a level-threshold interrupt. The RAM is instantiated beside this block and connected through the `ram_*` ports.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: RAM address width; depth = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: sample word width.
- `THRESH`, 1024: fill level at or above which `irq_level` asserts; legal range 1..2^ADDR_WIDTH.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `capture_en`  in  1: when 0, incoming samples are ignored; they are not counted as drops.
- `s_valid`  in  1: ADC sample strobe, one sample per cycle max; there is no back-pressure.
- `s_data`  in  DATA_WIDTH: ADC sample.
- `rd_req`  in  1: host read request, one word per cycle max.
- `rd_valid`  out  1: one-cycle pulse; `rd_data` is valid.
- `rd_data`  out  DATA_WIDTH: read word, driven straight from `ram_dout`.
- `flush`  in  1: synchronous clear of the buffer state.
- `clr_ovf`  in  1: clears `overflow` and `drop_cnt`.
- `level`  out  ADDR_WIDTH+1: current fill count, 0..2^ADDR_WIDTH.
- `empty`, `full`  out  1: `level`==0 and `level`==2^ADDR_WIDTH respectively.
- `overflow`  out  1: sticky flag; a sample was dropped.
- `drop_cnt`  out  16: dropped-sample count, saturating at 16'hFFFF.
- `irq_level`  out  1: registered; 1 when `level` >= THRESH.
- `ram_waddr`  out  ADDR_WIDTH, `ram_we`  out  1, `ram_din`  out  DATA_WIDTH: RAM write port.
- `ram_raddr`  out  ADDR_WIDTH, `ram_re`  out  1: RAM read port.
- `ram_dout`  in  DATA_WIDTH: RAM read data, valid one cycle after `ram_re`.

## Operation
- State registers: `wptr`, `rptr` (ADDR_WIDTH each, wrap modulo depth); `level` (ADDR_WIDTH+1); `rd_pend` (1); `overflow`; `drop_cnt`; `irq_level`.
- Write acceptance: `wr_acc` = `capture_en` & `s_valid` & ~`full` & ~`flush`.
- Write port is combinational: `ram_we`=`wr_acc`, `ram_waddr`=`wptr`, `ram_din`=`s_data`. On acceptance, `wptr` increments.
- Drop condition: `capture_en` & `s_valid` & `full` & ~`flush`. A drop sets `overflow` and increments `drop_cnt`, saturating. The sample is discarded; there is no overwrite of old data.
- Read acceptance: `rd_acc` = `rd_req` & ~`empty` & ~`flush`.
- Read port is combinational: `ram_re`=`rd_acc`, `ram_raddr`=`rptr`. On acceptance, `rptr` increments. A request while empty is ignored, with no error flag.
- Full and empty are evaluated on pre-edge `level`:
  - a write in the same cycle as a read of a full buffer is still dropped;
  - a read in the same cycle as a write into an empty buffer is refused.
  - Consequently the RAM never sees a read and a write to the same address in one cycle.
- Level update: `level` += `wr_acc` − `rd_acc`. A simultaneous accepted read and write leaves `level` unchanged.
- `rd_pend` <= `rd_acc`; `rd_valid` = `rd_pend`; `rd_data` = `ram_dout`.
- `flush`:
  - next edge clears `wptr`, `rptr`, `level`, `rd_pend`, `irq_level`, `overflow` and `drop_cnt`;
  - a read accepted in the cycle before `flush` still completes (`rd_valid` pulses normally).
- `clr_ovf`: next edge clears `overflow` and `drop_cnt`. If a drop occurs in the same cycle, the drop wins: `overflow`=1 and `drop_cnt`=1.
- `irq_level` <= (next `level` >= THRESH). It is level-sensitive, not sticky.

## Timing
- Reset values: `wptr`=`rptr`=0, `level`=0, `empty`=1, `full`=0, `rd_valid`=0, `overflow`=0, `drop_cnt`=0, `irq_level`=0.
- At reset, the combinational RAM strobes `ram_we` and `ram_re` evaluate to 0 for any `s_valid`/`rd_req`.
- Reset asserted mid-transfer aborts any pending read; `rd_valid` is not pulsed.
- Write: sample is in the RAM at the edge closing cycle N; `level`, `empty` and `full` reflect it from cycle N+1.
  - A sample written in N is readable by `rd_req` in N+1.
- Read latency: `rd_req` accepted in cycle N gives `rd_valid` and `rd_data` in cycle N+1. Back-to-back requests sustain 1 word/cycle.
- `irq_level` updates in the same cycle as `level`.

## Test plan
- Use ADDR_WIDTH=3, THRESH=6 for the bench.
- Basic FIFO:
  - stimulus: write 0x11, 0x22, 0x33 on consecutive cycles, then `rd_req` for 3 cycles;
  - response: `rd_valid` on 3 consecutive cycles, each one after its request, carrying 0x11, 0x22, 0x33; `level` 3→0; `empty`=1.
- Full and drop:
  - stimulus: write 10 samples 0..9 continuously;
  - response: `full`=1 after the 8th, `overflow`=1, `drop_cnt`=2, readout yields 0..7.
  - Then pulse `clr_ovf`: `overflow`=0, `drop_cnt`=0.
- Wrap-around:
  - stimulus: 20 cycles of simultaneous write and read with `level` held at 4, data incrementing from 0;
  - response: reads return data in order across the pointer wrap and `level` stays 4.
- Boundary refusals:
  - read of an empty buffer: no `ram_re`, no `rd_valid`;
  - read and write in one cycle on an empty buffer: only the write is accepted, `level`=1;
  - read and write in one cycle on a full buffer: the write is dropped, `drop_cnt`+1, `level`=7.
- Threshold:
  - stimulus: fill to 5, then to 6, then read 1;
  - response: `irq_level`=0, then 1, then 0.
- Flush and reset:
  - stimulus: `flush` with `level`=5 and `overflow`=1;
  - response: `level`=0, `empty`=1, `overflow`=0, pointers 0, and the next write lands at address 0.
  - Assert `rst` asynchronously mid-read: all outputs at reset values immediately, no `rd_valid`.
